// File: rtl/imem_boot_sequencer.sv
// -----------------------------------------------------------------------------
// imem_boot_sequencer
//
// Sequences the instruction-memory load/run flow of the processor:
//   1. A host streams a program over a valid/ready handshake. Each accepted
//      word is written into instruction memory one cycle later through
//      ld_en/Load_data.
//   2. rst_counter is pulsed for one cycle to rewind the PC.
//   3. The core runs with rd_en for run_cycles cycles (0 = unlimited) or
//      until halt_req is seen.
//   4. The sequencer halts. From there it can rerun the loaded program or
//      load a new one.
//
// Ports
//   clk          clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   start        begin a load session (honoured in IDLE and HALT only)
//   prog_len     words to load, legal range 1..2^ADDR_WIDTH
//   run_cycles   run length in cycles, 0 = unlimited; latched on start
//   rerun        in HALT: restart the already-loaded program
//   halt_req     in RUN: stop execution on the next cycle
//   s_valid      host word valid
//   s_data       host word
//   s_ready      sequencer accepts a word this cycle
//   ld_en        instruction-memory write strobe
//   Load_data    word written with ld_en
//   rst_counter  PC reset to the processor
//   rd_en        instruction fetch enable to the processor
//   load_addr    index of the next word to be accepted
//   cycle_count  RUN cycles elapsed in the current run (saturating)
//   busy         high in every state except IDLE and HALT
//   done         one-cycle pulse on HALT entry
//   err          one-cycle pulse when a start is rejected
//
// All outputs are registered. Each one is computed from the next state in the
// output process, so its value always matches the state shown in that cycle.
// -----------------------------------------------------------------------------
module imem_boot_sequencer #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned CNT_SIZE   = 32,
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   prog_len,
  input  logic [CNT_SIZE-1:0]   run_cycles,
  input  logic                  rerun,
  input  logic                  halt_req,
  input  logic                  s_valid,
  input  logic [WORD_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  ld_en,
  output logic [WORD_WIDTH-1:0] Load_data,
  output logic                  rst_counter,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] load_addr,
  output logic [CNT_SIZE-1:0]   cycle_count,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDrain,
    StRestart,
    StRun,
    StHalt
  } state_e;

  localparam logic [ADDR_WIDTH:0] MaxLen = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] LenOne = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [CNT_SIZE-1:0] CntOne = {{(CNT_SIZE-1){1'b0}}, 1'b1};

  state_e state_q, state_d;

  logic [ADDR_WIDTH:0]   prog_len_q, prog_len_d;
  logic [CNT_SIZE-1:0]   run_cycles_q, run_cycles_d;
  // One bit wider than load_addr so a full-depth load can be counted to the end.
  logic [ADDR_WIDTH:0]   load_cnt_q, load_cnt_d;
  logic [CNT_SIZE-1:0]   cycle_count_q, cycle_count_d;
  logic                  s_ready_q, s_ready_d;
  logic                  ld_en_q, ld_en_d;
  logic [WORD_WIDTH-1:0] load_data_q, load_data_d;
  logic                  rst_counter_q, rst_counter_d;
  logic                  rd_en_q, rd_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  // Decoded conditions shared by the next-state and output processes.
  logic start_ok;
  logic start_phase;
  logic start_take;
  logic accept;
  logic last_word;
  logic limit_hit;

  always_comb begin
    start_ok    = (prog_len != '0) && (prog_len <= MaxLen);
    start_phase = (state_q == StIdle) || (state_q == StHalt);
    start_take  = start_phase && start && start_ok;
    // s_ready_q is only ever high in LOAD, so it qualifies the accept alone.
    accept      = s_valid && s_ready_q;
    last_word   = accept && ((load_cnt_q + LenOne) == prog_len_q);
    limit_hit   = (run_cycles_q != '0) && (cycle_count_q == (run_cycles_q - CntOne));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_take) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (last_word) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        state_d = StRestart;
      end
      StRestart: begin
        state_d = StRun;
      end
      StRun: begin
        // The limit and halt_req may coincide; both lead to one HALT entry.
        if (halt_req || limit_hit) begin
          state_d = StHalt;
        end
      end
      StHalt: begin
        // start has priority over rerun, even when the start is rejected.
        if (start) begin
          if (start_ok) begin
            state_d = StLoad;
          end
        end else if (rerun) begin
          state_d = StRestart;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output and datapath next-state logic.
  always_comb begin
    prog_len_d    = prog_len_q;
    run_cycles_d  = run_cycles_q;
    load_cnt_d    = load_cnt_q;
    cycle_count_d = cycle_count_q;
    load_data_d   = load_data_q;

    if (start_take) begin
      prog_len_d   = prog_len;
      run_cycles_d = run_cycles;
      load_cnt_d   = '0;
    end else if (accept) begin
      load_cnt_d = load_cnt_q + LenOne;
    end

    // Write strobe trails the accept by one cycle.
    ld_en_d = accept;
    if (accept) begin
      load_data_d = s_data;
    end

    if (state_d == StRestart) begin
      cycle_count_d = '0;
    end else if ((state_q == StRun) && (cycle_count_q != '1)) begin
      cycle_count_d = cycle_count_q + CntOne;
    end

    s_ready_d = (state_d == StLoad);
    rd_en_d   = (state_d == StRestart) || (state_d == StRun);
    // The PC reset is held in IDLE, LOAD and RESTART but dropped on memory write
    // cycles, so ld_en and rst_counter never reach the core together.
    rst_counter_d = ((state_d == StIdle) || (state_d == StLoad) || (state_d == StRestart))
                    && !ld_en_d;
    busy_d = !((state_d == StIdle) || (state_d == StHalt));
    done_d = (state_d == StHalt) && (state_q != StHalt);
    err_d  = start_phase && start && !start_ok;
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prog_len_q    <= '0;
      run_cycles_q  <= '0;
      load_cnt_q    <= '0;
      cycle_count_q <= '0;
      s_ready_q     <= 1'b0;
      ld_en_q       <= 1'b0;
      load_data_q   <= '0;
      rst_counter_q <= 1'b1;
      rd_en_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      prog_len_q    <= prog_len_d;
      run_cycles_q  <= run_cycles_d;
      load_cnt_q    <= load_cnt_d;
      cycle_count_q <= cycle_count_d;
      s_ready_q     <= s_ready_d;
      ld_en_q       <= ld_en_d;
      load_data_q   <= load_data_d;
      rst_counter_q <= rst_counter_d;
      rd_en_q       <= rd_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign ld_en       = ld_en_q;
  assign Load_data   = load_data_q;
  assign rst_counter = rst_counter_q;
  assign rd_en       = rd_en_q;
  // Full-depth loads wrap load_addr back to 0 on the final accept.
  assign load_addr   = load_cnt_q[ADDR_WIDTH-1:0];
  assign cycle_count = cycle_count_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

  // Processor-side strobe invariants.
  a_ld_vs_rd : assert property (@(posedge clk) disable iff (rst) !(ld_en_q && rd_en_q));
  a_ld_vs_rc : assert property (@(posedge clk) disable iff (rst) !(ld_en_q && rst_counter_q));

endmodule
